// File: rtl/clock_core_12h_pkg.sv
// Shared definitions for the 12-hour timekeeping core: mode encodings,
// reset values, field limits and small field-advance helpers.
package clock_pkg;

  localparam logic [1:0] MODE_RUN = 2'b00;
  localparam logic [1:0] MODE_SET = 2'b01;

  localparam logic [3:0] HR_RESET = 4'd12;
  localparam logic       AP_AM    = 1'b0;
  localparam logic       AP_PM    = 1'b1;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [3:0] HR_MAX   = 4'd12;
  // Hour value whose successor flips AM/PM.
  localparam logic [3:0] HR_FLIP  = 4'd11;

  typedef struct packed {
    logic [5:0] sec;
    logic [5:0] min;
    logic [3:0] hr;
    logic       ap;
  } clk_time_t;

  // 12 -> 1 -> 2 ... -> 11 -> 12
  function automatic logic [3:0] next_hr(input logic [3:0] h);
    return (h == HR_MAX) ? 4'd1 : h + 4'd1;
  endfunction

  // 0..max wrap-around increment for the 6-bit sec/min fields.
  function automatic logic [5:0] wrap_inc6(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/clock_core_12h_if.sv
// Control/time bundle between the clock controller (master) and the
// timekeeping core (slave).
interface clock_core_12h_if;
  import clock_pkg::*;

  // Handshake: there is no valid/ready pair. mode is a level sampled every
  // rising edge; inc_hr/inc_min are single-cycle debounced pulses, each high
  // cycle counts as exactly one press. All time outputs are registered and
  // sec_tick is high for exactly one cycle when a new second appears.
  logic [1:0] mode;
  logic       inc_hr;
  logic       inc_min;
  logic [5:0] sec;
  logic [5:0] min;
  logic [3:0] hr;
  logic       ap;
  logic       sec_tick;

  modport master (
    output mode, inc_hr, inc_min,
    input  sec, min, hr, ap, sec_tick
  );

  modport slave (
    input  mode, inc_hr, inc_min,
    output sec, min, hr, ap, sec_tick
  );

endinterface

// File: rtl/clock_core_12h_tick_prescaler.sv
// Divides the system clock to a one-cycle tick every CLK_HZ cycles.
// While hold is high the count is parked at zero so a partial second is
// discarded and counting restarts cleanly once hold drops.
module tick_prescaler #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  output logic tick
);

  localparam int              CNT_W = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] TC   = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = !hold && (cnt_q == TC);

  // Next count: park at zero on hold, wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (hold || tick) begin
      cnt_d = '0;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_core_12h.sv
// 12-hour timekeeping core: sec/min/hr fields with AM/PM flag advanced by a
// 1 Hz tick, or by debounced inc_hr/inc_min pulses while in set mode.
// Optional build macro CLR_SEC_ON_SET_EN: when defined, seconds are held at
// zero throughout set mode so time resumes at hh:mm:00.
module clock_core_12h
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic               clk,
  input  logic               reset,
  clock_core_12h_if.slave    bus
);

  logic      set_mode;
  logic      tick;
  clk_time_t time_q;
  clk_time_t time_d;
  logic      sec_tick_q;
  logic      sec_tick_d;

  assign set_mode = (bus.mode == MODE_SET);

  tick_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .hold  (set_mode),
    .tick  (tick)
  );

  // Next time: tick-driven carry chain in run modes, button edits in set mode.
  always_comb begin
    time_d     = time_q;
    sec_tick_d = 1'b0;
    if (tick) begin
      sec_tick_d = 1'b1;
      time_d.sec = wrap_inc6(time_q.sec, SEC_MAX);
      if (time_q.sec == SEC_MAX) begin
        time_d.min = wrap_inc6(time_q.min, MIN_MAX);
        if (time_q.min == MIN_MAX) begin
          time_d.hr = next_hr(time_q.hr);
          if (time_q.hr == HR_FLIP) begin
            time_d.ap = ~time_q.ap;
          end
        end
      end
    end else if (set_mode) begin
      // Minute edits never carry into the hour.
      if (bus.inc_min) begin
        time_d.min = wrap_inc6(time_q.min, MIN_MAX);
      end
      if (bus.inc_hr) begin
        time_d.hr = next_hr(time_q.hr);
        if (time_q.hr == HR_FLIP) begin
          time_d.ap = ~time_q.ap;
        end
      end
`ifdef CLR_SEC_ON_SET_EN
      time_d.sec = 6'd0;
`else
      time_d.sec = time_q.sec;
`endif
    end
  end

  // Time and tick registers; reset gives 12:00:00 AM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      time_q.sec <= 6'd0;
      time_q.min <= 6'd0;
      time_q.hr  <= HR_RESET;
      time_q.ap  <= AP_AM;
      sec_tick_q <= 1'b0;
    end else begin
      time_q     <= time_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  assign bus.sec      = time_q.sec;
  assign bus.min      = time_q.min;
  assign bus.hr       = time_q.hr;
  assign bus.ap       = time_q.ap;
  assign bus.sec_tick = sec_tick_q;

endmodule

// File: tb/tb_clock_core_12h.sv
// Bench for clock_core_12h with CLK_HZ=4. The reference model keeps a
// 24-hour clock (h24 0..23) plus prescaler count and converts to 12-hour
// form when predicting outputs. Expected vectors are queued as each cycle
// is driven and popped after the edge.
module tb_clock_core_12h;
  import clock_pkg::*;

  localparam int CLK_HZ = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  clock_core_12h_if bus ();

  clock_core_12h #(
    .CLK_HZ (CLK_HZ)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [17:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  int m_h24, m_min, m_sec, m_cnt;
  bit m_tick;
  int sec_before;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string tag);
    vectors++;
    miscompares++;
    $display("FAIL %s: cycle budget expired at %0t", tag, $time);
  endtask

  function automatic logic [17:0] model_pack();
    logic [3:0] h12;
    h12 = ((m_h24 % 12) == 0) ? 4'd12 : 4'(m_h24 % 12);
    return {6'(m_sec), 6'(m_min), h12, (m_h24 >= 12), m_tick};
  endfunction

  function automatic logic [17:0] dut_pack();
    return {bus.sec, bus.min, bus.hr, bus.ap, bus.sec_tick};
  endfunction

  task automatic model_step(input logic rst_n, input logic [1:0] md,
                            input logic ih, input logic im);
    if (!rst_n) begin
      m_h24 = 0; m_min = 0; m_sec = 0; m_cnt = 0; m_tick = 0;
    end else if (md == 2'b01) begin
      m_tick = 0;
      m_cnt  = 0;
      if (im) m_min = (m_min + 1) % 60;
      if (ih) m_h24 = (m_h24 + 1) % 24;
`ifdef CLR_SEC_ON_SET_EN
      m_sec = 0;
`endif
    end else if (m_cnt == CLK_HZ - 1) begin
      m_cnt  = 0;
      m_tick = 1;
      m_sec  = m_sec + 1;
      if (m_sec == 60) begin
        m_sec = 0;
        m_min = m_min + 1;
        if (m_min == 60) begin
          m_min = 0;
          m_h24 = (m_h24 + 1) % 24;
        end
      end
    end else begin
      m_cnt  = m_cnt + 1;
      m_tick = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic rst_n, input logic [1:0] md,
                       input logic ih, input logic im);
    logic [17:0] exp;
    reset       = rst_n;
    bus.mode    = md;
    bus.inc_hr  = ih;
    bus.inc_min = im;
    model_step(rst_n, md, ih, im);
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    bus.inc_hr  = 1'b0;
    bus.inc_min = 1'b0;
    exp = exp_q.pop_front();
    check_eq("cycle", 32'(dut_pack()), 32'(exp));
  endtask

  task automatic pulses(input int n, input logic ih, input logic im);
    for (int i = 0; i < n; i++) cycle(1'b1, 2'b01, ih, im);
  endtask

  task automatic check_time(input string tag, input int h, input int mi,
                            input int s, input int a, input int t);
    check_eq({tag, "_hr"},   32'(bus.hr),       32'(h));
    check_eq({tag, "_min"},  32'(bus.min),      32'(mi));
    check_eq({tag, "_sec"},  32'(bus.sec),      32'(s));
    check_eq({tag, "_ap"},   32'(bus.ap),       32'(a));
    check_eq({tag, "_tick"}, 32'(bus.sec_tick), 32'(t));
  endtask

  // Run until the model reaches the given 24-hour time on a tick.
  task automatic run_until(input string tag, input int h24, input int mi,
                           input int s, input int budget);
    int n = 0;
    while (!(m_tick && m_h24 == h24 && m_min == mi && m_sec == s)) begin
      if (n >= budget) begin
        timeout_fail(tag);
        return;
      end
      cycle(1'b1, 2'b00, 1'b0, 1'b0);
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b0;
    bus.mode    = 2'b00;
    bus.inc_hr  = 1'b0;
    bus.inc_min = 1'b0;
    m_h24 = 0; m_min = 0; m_sec = 0; m_cnt = 0; m_tick = 0;

    // Reset state, then first tick 4 cycles after release.
    cycle(1'b0, 2'b00, 1'b0, 1'b0);
    check_time("reset", 12, 0, 0, 0, 0);
    cycle(1'b0, 2'b01, 1'b1, 1'b1);
    check_time("reset_override", 12, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 2'b00, 1'b0, 1'b0);
      check_eq("first_tick", 32'(bus.sec_tick), 32'(i == 4));
    end
    check_eq("first_sec", 32'(bus.sec), 32'd1);

    // 13 hour presses from 12 AM.
    for (int i = 1; i <= 13; i++) begin
      cycle(1'b1, 2'b01, 1'b1, 1'b0);
      check_eq("inc_hr_hr", 32'(bus.hr), 32'((i <= 11) ? i : ((i == 12) ? 12 : 1)));
      check_eq("inc_hr_ap", 32'(bus.ap), 32'(i >= 12));
    end
    // 61 minute presses: min wraps to 1, hour untouched.
    pulses(61, 1'b0, 1'b1);
    check_eq("inc_min_min", 32'(bus.min), 32'd1);
    check_eq("inc_min_hr",  32'(bus.hr),  32'd1);

    // Go to 11:59 AM, then press both at once.
    pulses(22, 1'b1, 1'b0);
    pulses(58, 1'b0, 1'b1);
    check_eq("pre_both_hr", 32'(bus.hr), 32'd11);
    cycle(1'b1, 2'b01, 1'b1, 1'b1);
    check_eq("both_hr",  32'(bus.hr),  32'd12);
    check_eq("both_min", 32'(bus.min), 32'd0);
    check_eq("both_ap",  32'(bus.ap),  32'd1);
    // Same presses in run and other modes are ignored.
    cycle(1'b1, 2'b00, 1'b1, 1'b1);
    check_eq("run_ign_hr", 32'(bus.hr), 32'd12);
    cycle(1'b1, 2'b10, 1'b1, 1'b1);
    check_eq("oth_ign_min", 32'(bus.min), 32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 2'b11, 1'b0, 1'b0);

    // Preload 11:59:xx AM and run into noon.
    pulses(23, 1'b1, 1'b0);
    pulses(59, 1'b0, 1'b1);
    run_until("noon", 12, 0, 0, 61 * CLK_HZ + 8);
    check_time("noon", 12, 0, 0, 1, 1);

    // Preload 11:59:xx PM and run into midnight.
    pulses(11, 1'b1, 1'b0);
    pulses(59, 1'b0, 1'b1);
    run_until("midnight", 0, 0, 0, 61 * CLK_HZ + 8);
    check_time("midnight", 12, 0, 0, 0, 1);

    // Enter set mode 2 cycles into a second, leave 10 cycles later.
    cycle(1'b1, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 2'b00, 1'b0, 1'b0);
    sec_before = m_sec;
    pulses(10, 1'b0, 1'b0);
`ifdef CLR_SEC_ON_SET_EN
    check_eq("set_sec", 32'(bus.sec), 32'd0);
`else
    check_eq("set_sec", 32'(bus.sec), 32'(sec_before));
`endif
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 2'b00, 1'b0, 1'b0);
      check_eq("resume_gap", 32'(bus.sec_tick), 32'(i == 4));
    end

    // Preload 11:59:59 PM and reset on the carrying edge.
    pulses(23, 1'b1, 1'b0);
    pulses(59, 1'b0, 1'b1);
    begin
      int n = 0;
      while (!(m_sec == 59 && m_cnt == CLK_HZ - 1 && m_h24 == 23 && m_min == 59)) begin
        if (n >= 61 * CLK_HZ + 8) break;
        cycle(1'b1, 2'b00, 1'b0, 1'b0);
        n++;
      end
      if (n >= 61 * CLK_HZ + 8) timeout_fail("reach_2359_59");
    end
    cycle(1'b0, 2'b00, 1'b0, 1'b0);
    check_time("reset_carry", 12, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 2'b00, 1'b0, 1'b0);
      check_eq("post_reset_tick", 32'(bus.sec_tick), 32'(i == 4));
    end
    check_time("post_reset", 12, 0, 1, 0, 1);

    // Random presses across modes, model-checked every cycle.
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
